// File: rtl/lsu_master.sv
// RV32I load/store initiator: validates alignment/funct3, issues one word-aligned
// byte-enabled bus transaction per request and returns an extended one-cycle response.
module lsu_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [31:0] rsp_rdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              TLAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = TLAST[CNT_W-1:0];

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic             bad_req;
    logic [3:0]       be_dec;
    logic [31:0]      wd_dec;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             timed_out;

    assign lsu_ready = (state == S_IDLE);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    // Request decode: illegal funct3 for the direction, or address not size-aligned
    always_comb begin
        bad_req = 1'b0;
        if (lsu_we) bad_req = lsu_funct3[2] | (lsu_funct3[1:0] == 2'b11);
        else        bad_req = (lsu_funct3[1:0] == 2'b11) | (lsu_funct3 == 3'b110);
        if ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0])        bad_req = 1'b1;
        if ((lsu_funct3[1:0] == 2'b10) && (|lsu_addr[1:0]))   bad_req = 1'b1;
        case (lsu_funct3[1:0])
            2'b00:   begin be_dec = 4'b0001 << lsu_addr[1:0]; wd_dec = {4{lsu_wdata[7:0]}};  end
            2'b01:   begin be_dec = 4'b0011 << lsu_addr[1:0]; wd_dec = {2{lsu_wdata[15:0]}}; end
            default: begin be_dec = 4'b1111;                  wd_dec = lsu_wdata;            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (lsu_valid) begin
                    we_q  <= lsu_we;
                    f3_q  <= lsu_funct3;
                    off_q <= lsu_addr[1:0];
                    if (bad_req) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end else begin
                        state     <= S_REQ;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {lsu_addr[31:2], 2'b00};
                        mem_we    <= lsu_we;
                        mem_be    <= be_dec;
                        mem_wdata <= wd_dec;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (we_q) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b0;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end
                    end else if (timed_out) begin
                        mem_req   <= 1'b0;
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= ld_data;
                    end else if (timed_out) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_master.sv
// Randomized bench for lsu_master: a per-transaction schedule model predicts bus
// activity, response cycle, fault and extended data for every accepted request.
module tb_lsu_master;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int nvec = 0;
    int nerr = 0;

    lsu_master #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One request: gd = REQ cycles before grant, rd = WAIT cycles before rvalid
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int gd, input int rd);
        bit          legal;
        int          nb, req_last, ws, done_k, sh;
        logic        exp_fault;
        logic [31:0] exp_rd, exp_be, exp_wd, v;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (legal && (a % nb) != 0) legal = 0;
        exp_be = ((32'd1 << nb) - 1) << a[1:0];
        exp_wd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                 (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        sh = 8 * int'(a[1:0]);
        v  = rw >> sh;
        if (nb == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        ws = gd + 2;
        exp_rd = 32'd0;
        exp_fault = 1'b1;
        req_last = 0;
        if (!legal) done_k = 1;
        else if (gd >= T) begin req_last = T; done_k = T + 1; end
        else if (we) begin req_last = gd + 1; done_k = gd + 2; exp_fault = 1'b0; end
        else begin
            req_last = gd + 1;
            if (rd >= T) done_k = ws + T;
            else begin done_k = ws + rd + 1; exp_fault = 1'b0; exp_rd = v; end
        end

        chk("ready_idle", lsu_ready, 1'b1);
        lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_funct3 = 3'($urandom); lsu_we = 1'($urandom);
        for (int k = 1; k <= done_k + 1; k++) begin
            chk("mem_req", mem_req, k <= req_last);
            if (k <= req_last) begin
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_be", mem_be, exp_be);
                chk("mem_we", mem_we, we);
                if (we) chk("mem_wdata", mem_wdata, exp_wd);
            end
            chk("rsp_valid", rsp_valid, k == done_k);
            if (k == done_k) begin
                chk("rsp_fault", rsp_fault, exp_fault);
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            chk("lsu_ready", lsu_ready, k > done_k);
            mem_gnt = legal && gd < T && k == gd + 1;
            if (legal && !we && gd < T && rd < T && k == ws + rd) begin
                mem_rvalid = 1'b1; mem_rdata = rw;
            end else begin
                // spurious rvalid while requesting or back in IDLE must be ignored
                mem_rvalid = (k <= gd && k <= req_last) || (k == done_k + 1);
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("rsp_after", rsp_valid, 1'b0);
        chk("rdata_hold", rsp_rdata, exp_rd);
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        #1;
        chk("rst_ready", lsu_ready, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_rsp", rsp_valid, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF7F01, 0, 0);  // LB
        do_txn(1'b0, 3'b101, 32'h00000042, 32'h0,        32'hBEEF1234, 0, 0);  // LHU
        do_txn(1'b0, 3'b001, 32'h00000042, 32'h0,        32'hBEEF1234, 1, 2);  // LH
        do_txn(1'b1, 3'b000, 32'h00000011, 32'h000000AB, 32'h0,        3, 0);  // SB
        do_txn(1'b0, 3'b010, 32'h00000006, 32'h0,        32'h0,        0, 0);  // LW misaligned
        do_txn(1'b1, 3'b001, 32'h00000005, 32'h1234,     32'h0,        0, 0);  // SH misaligned
        do_txn(1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        0, 0);  // bad funct3
        do_txn(1'b0, 3'b010, 32'h00000100, 32'h0,        32'h12345678, 0, 9);  // WAIT timeout
        do_txn(1'b1, 3'b010, 32'h00000200, 32'hCAFEF00D, 32'h0,        9, 0);  // REQ timeout
        do_txn(1'b0, 3'b100, 32'h00000301, 32'h0,        32'h0000F100, T-1, T-1); // last-cycle wins

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            do_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        // Reset while waiting for read data
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h00000400;
        @(posedge clk); #1;
        lsu_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("in_wait", mem_req, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_rsp", rsp_valid, 1'b0);
        chk("arst_be", mem_be, 4'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_fault", rsp_fault, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_rsp", rsp_valid, 1'b0);
            chk("post_rst_ready", lsu_ready, 1'b1);
            mem_rvalid = 1'b1;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        do_txn(1'b0, 3'b010, 32'h00000400, 32'h0, 32'hA5A55A5A, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
Load/store initiator between the core's execute stage and a word-organised data memory with byte enables. It accepts one RV32I load/store per handshake and validates alignment and funct3. It converts byte/half/word accesses into a single word-aligned bus transaction with a byte-enable mask and replicated write data. It extracts and sign- or zero-extends load data, and returns a one-cycle response that may carry a fault flag.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ or WAIT before aborting with fault; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
lsu_valid  in  1  core request valid
lsu_ready  out  1  block can accept a request (high only in IDLE)
lsu_we  in  1  1=store, 0=load
lsu_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle completion pulse
rsp_fault  out  1  qualifies rsp_valid: misaligned, illegal funct3 or timeout
rsp_rdata  out  32  extended load data; 0 for stores and faults
mem_req  out  1  bus request, held until mem_gnt
mem_gnt  in  1  bus accepts request this cycle
mem_addr  out  32  {addr[31:2],2'b00}
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_wdata  out  32  replicated write data
mem_rvalid  in  1  read data valid (loads only, strictly after gnt)
mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset is asynchronous: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_fault=0, rsp_rdata=0. lsu_ready=1 in IDLE, including immediately after reset.
- Accept on lsu_valid & lsu_ready: latch addr, we, funct3, wdata; decode and check in the same cycle.
- Fault on accept: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111; store funct3 other than 000/001/010. Faulted request goes IDLE->DONE with no mem_req, rsp_fault=1, rsp_rdata=0.
- Legal request goes IDLE->REQ. mem_addr, mem_we, mem_be and mem_wdata are registered and stable while mem_req=1.
- Byte enables: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111. The same mask is driven for loads.
- Write data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- REQ: mem_req=1. On mem_gnt, a store goes to DONE (completes on grant) and a load goes to WAIT. mem_req drops the cycle after gnt. mem_rvalid in REQ or IDLE is ignored.
- WAIT: on mem_rvalid, capture mem_rdata, select the byte (off) or half (off[1]), sign-extend for LB/LH or zero-extend for LBU/LHU, then go to DONE.
- Timeout: counter clears on entry to REQ and WAIT and increments each cycle there. When counter==TIMEOUT_CYCLES-1 and no gnt/rvalid arrives that cycle, go to DONE with fault and drop mem_req. A gnt/rvalid on the final cycle wins over the timeout.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_fault hold their values until the next DONE. rsp_valid and lsu_ready are never both high.
- Minimum latency from accept edge to rsp_valid: fault 1 cycle; store 2 cycles (gnt in first REQ cycle); load 3 cycles (gnt, then rvalid next cycle).
- Reset mid-operation aborts immediately: mem_req drops asynchronously and no rsp_valid is produced for the aborted request.

Test Plan:
- LB at 0x00000103, mem_rdata=0x80FF7F01 with gnt in 1st REQ cycle and rvalid next -> mem_addr=0x00000100, mem_be=4'b1000, rsp_rdata=0xFFFFFF80 3 cycles after accept, rsp_fault=0.
- LHU at 0x00000042, mem_rdata=0xBEEF1234 -> mem_be=4'b1100, rsp_rdata=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- SB 0x000000AB at 0x00000011, mem_gnt delayed 3 cycles -> mem_req held 4 cycles with mem_be=4'b0010, mem_wdata=0xABABABAB, mem_we=1 stable; rsp_valid pulses once, rsp_rdata=0.
- LW at 0x00000006, and SH at 0x00000005 -> no mem_req, rsp_valid+rsp_fault the cycle after accept; funct3=3'b011 load faults the same way.
- TIMEOUT_CYCLES=4, load granted but rvalid never arrives -> rsp_fault=1 after 4 WAIT cycles, block returns to IDLE; a late mem_rvalid is ignored.
- Assert rst while in WAIT -> mem_req=0 and all outputs 0 immediately, lsu_ready=1 after release, no rsp_valid; the next LW completes normally.
